top_puf: RTL and testbench



---
 rtl/top_puf.sv | 92 +++++++++
 tb/tb_top_puf.sv | 66 ++++++
 2 files changed

// File: rtl/top_puf.sv
// top_puf: dual-core arbiter PUF with PDL delays; define PUF_TIEBREAK_EN for LFSR-resolved ties
module top_puf #(
  parameter int WIDTH       = 32,
  parameter int CHAL_WEIGHT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic [WIDTH-1:0] config1,
  input  logic [WIDTH-1:0] config2,
  output logic [WIDTH-1:0] c
);
  typedef enum logic [1:0] {LAUNCH, RACE, DECIDE} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d, d0_q, d0_d, d1_q, d1_d;
  logic arr0_q, arr0_d, arr1_q, arr1_d, win0_q, win0_d, tie_q, tie_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic hit0, hit1, tie_bit, r;
`ifdef PUF_TIEBREAK_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign tie_bit = lfsr_q[0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) lfsr_q <= 8'hA5;
    else lfsr_q <= lfsr_d;
`else
  assign tie_bit = 1'b0;
`endif
  assign hit0 = state_q == RACE && cnt_q == d0_q && !arr0_q;
  assign hit1 = state_q == RACE && cnt_q == d1_q && !arr1_q;
  assign r    = tie_q ? tie_bit : win0_q;
  assign c    = c_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    arr0_d  = arr0_q;
    arr1_d  = arr1_q;
    win0_d  = win0_q;
    tie_d   = tie_q;
    c_d     = c_q;
    case (state_q)
      LAUNCH: begin
        d0_d    = 6'($countones(config1)) + (a ? 6'(CHAL_WEIGHT) : 6'd0) + 6'd1;
        d1_d    = 6'($countones(config2)) + (b ? 6'(CHAL_WEIGHT) : 6'd0) + 6'd1;
        cnt_d   = 6'd1;
        arr0_d  = 1'b0;
        arr1_d  = 1'b0;
        win0_d  = 1'b0;
        tie_d   = 1'b0;
        state_d = RACE;
      end
      RACE: begin
        cnt_d   = cnt_q + 6'd1;
        arr0_d  = arr0_q | hit0;
        arr1_d  = arr1_q | hit1;
        win0_d  = win0_q | (hit0 && !hit1 && !arr1_q);
        tie_d   = tie_q | (hit0 && hit1);
        state_d = (arr0_d && arr1_d) ? DECIDE : RACE;
      end
      DECIDE: begin
        c_d     = {c_q[WIDTH-2:0], r};
        state_d = LAUNCH;
      end
      default: state_d = LAUNCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= LAUNCH;
      cnt_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      arr0_q  <= 1'b0;
      arr1_q  <= 1'b0;
      win0_q  <= 1'b0;
      tie_q   <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      arr0_q  <= arr0_d;
      arr1_q  <= arr1_d;
      win0_q  <= win0_d;
      tie_q   <= tie_d;
      c_q     <= c_d;
    end
endmodule

// File: tb/tb_top_puf.sv
// tb_top_puf: directed checks of round timing, response bits, ties and async reset
module tb_top_puf;
  logic clk, reset, a, b;
  logic [31:0] config1, config2, c;
  int checks, errors;
  top_puf dut (.clk(clk), .reset(reset), .a(a), .b(b), .config1(config1), .config2(config2), .c(c));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] exp);
    checks++;
    assert (c === exp) else begin
      errors++;
      $error("FAIL %s: c=%h expected %h", tag, c, exp);
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    reset = 1; a = 0; b = 0; config1 = 32'h0; config2 = 32'hFFFFFFFF;
    #2 reset = 0;
    #1 chk("reset", 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1;
    tick(34); chk("s1_before_first_decide", 32'h0);
    tick(1);  chk("s1_first_decide", 32'h1);
    tick(17); chk("s1_stable_mid_round", 32'h1);
    tick(18); chk("s1_second_round", 32'h3);
    tick(35 * 30); chk("s1_32_rounds", 32'hFFFFFFFF);
    config1 = 32'hFFFFFFFF; config2 = 32'h0;
    tick(35); chk("s2_first_zero", 32'hFFFFFFFE);
    tick(35 * 31); chk("s2_32_rounds", 32'h0);
    reset = 0; a = 1; b = 0; config1 = 32'h0; config2 = 32'h0;
    @(negedge clk) reset = 1;
    tick(4); chk("s4_round1_pending", 32'h0);
    tick(1); chk("s4_round1_r0", 32'h0);
    a = 0; b = 1;
    tick(4); chk("s4_round2_pending", 32'h0);
    tick(1); chk("s4_round2_r1", 32'h1);
    config1 = 32'h000000FF; config2 = 32'h000000FF; a = 0; b = 0;
    tick(10); chk("s3_tie_pending", 32'h1);
    tick(1);  chk("s3_tie_shifts_0", 32'h2);
    tick(22); chk("s3_three_ties", 32'h8);
    config1 = 32'h0; config2 = 32'h0; a = 0; b = 1;
    tick(1);
    a = 1; b = 0; config2 = 32'hFFFFFFFF;
    tick(3); chk("s6_period_from_launch", 32'h8);
    tick(1); chk("s6_bit_from_launch", 32'h11);
    a = 0;
    tick(10);
    #2 reset = 0;
    #1 chk("s5_async_reset", 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("s5_held_in_reset", 32'h0);
    @(negedge clk) reset = 1;
    tick(34); chk("s5_before_first_decide", 32'h0);
    tick(1);  chk("s5_first_decide", 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
